// File: rtl/seg7_pair_decoder.sv
// Display readback monitor: recovers 0..15 from a pair of active-low 7-segment digits
// once the synchronised pattern has held stable, flagging undecodable glyph pairs.

module seg7_pair_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       seg_tens,
    input  logic [6:0]       seg_units,
    output logic [3:0]       out_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             overflow,
    input  logic             clr
);

    localparam logic [13:0] BLANK    = 14'h3FFF;
    localparam logic [7:0]  STABLE_N = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {WAIT, SETTLE, COMMIT} state_t;

    state_t             state_q;
    logic [13:0]        sync1_q, sync2_q, last_q, cand_q;
    logic [7:0]         cnt_q;
    logic [3:0]         outValue_q, outValue_d;
    logic               outValid_q, outValid_d;
    logic               overflow_q, overflow_d;
    logic               errPulse_q;
    logic [ERR_W-1:0]   errCount_q, errCount_d;

    logic [4:0]         tensD, unitsD;
    logic [6:0]         sum;
    logic               candOk, commitLive, deliver, invalid;

    // Returns {is_glyph, digit}; anything outside the ten glyphs is not a digit.
    function automatic logic [4:0] glyphDigit(input logic [6:0] g);
        case (g)
            7'b0000001: return {1'b1, 4'd0};
            7'b1001111: return {1'b1, 4'd1};
            7'b0010010: return {1'b1, 4'd2};
            7'b0000110: return {1'b1, 4'd3};
            7'b1001100: return {1'b1, 4'd4};
            7'b0100100: return {1'b1, 4'd5};
            7'b0100000: return {1'b1, 4'd6};
            7'b0001111: return {1'b1, 4'd7};
            7'b0000000: return {1'b1, 4'd8};
            7'b0000100: return {1'b1, 4'd9};
            default:    return 5'd0;
        endcase
    endfunction

    // Range check happens on the full sum before truncating to the 4-bit result.
    always_comb begin
        tensD      = glyphDigit(cand_q[13:7]);
        unitsD     = glyphDigit(cand_q[6:0]);
        sum        = 7'(tensD[3:0]) * 7'd10 + 7'(unitsD[3:0]);
        candOk     = tensD[4] && unitsD[4] && (tensD[3:0] <= 4'd1) && (sum <= 7'd15);
        commitLive = (state_q == COMMIT) && (cand_q != BLANK);
        deliver    = commitLive && candOk;
        invalid    = commitLive && !candOk;
    end

    // A delivery into a full, stalled register is dropped; a same-cycle transfer frees the slot.
    always_comb begin
        outValid_d = outValid_q;
        outValue_d = outValue_q;
        overflow_d = clr ? 1'b0 : overflow_q;
        errCount_d = clr ? '0 : errCount_q;
        if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
        if (deliver) begin
            if (!outValid_q || out_ready) begin
                outValid_d = 1'b1;
                outValue_d = sum[3:0];
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (invalid && (errCount_d != {ERR_W{1'b1}})) begin
            errCount_d = errCount_d + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= BLANK;
            sync2_q    <= BLANK;
            last_q     <= BLANK;
            cand_q     <= BLANK;
            cnt_q      <= 8'd0;
            state_q    <= WAIT;
            outValue_q <= 4'd0;
            outValid_q <= 1'b0;
            overflow_q <= 1'b0;
            errPulse_q <= 1'b0;
            errCount_q <= '0;
        end else begin
            sync1_q    <= {seg_tens, seg_units};
            sync2_q    <= sync1_q;
            outValue_q <= outValue_d;
            outValid_q <= outValid_d;
            overflow_q <= overflow_d;
            errPulse_q <= invalid;
            errCount_q <= errCount_d;
            case (state_q)
                WAIT: begin
                    if (sync2_q != last_q) begin
                        cand_q  <= sync2_q;
                        cnt_q   <= 8'd1;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (sync2_q != cand_q) begin
                        cand_q <= sync2_q;
                        cnt_q  <= 8'd1;
                    end else if (cnt_q >= STABLE_N) begin
                        state_q <= COMMIT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                COMMIT: begin
                    last_q  <= cand_q;
                    state_q <= WAIT;
                end
                default: state_q <= WAIT;
            endcase
        end
    end

    assign out_value = outValue_q;
    assign out_valid = outValid_q;
    assign overflow  = overflow_q;
    assign err_pulse = errPulse_q;
    assign err_count = errCount_q;

endmodule
